// File: rtl/dmem_stack_sequencer_pkg.sv
// Shared definitions for the data-memory stack sequencer: opcodes, write-data
// select encodings and the FSM state type.
package dmem_stack_sequencer_pkg;

  typedef logic [2:0] opcode_t;
  typedef logic [1:0] dsel_t;

  localparam opcode_t OP_LOAD  = 3'd0;
  localparam opcode_t OP_STORE = 3'd1;
  localparam opcode_t OP_PUSH  = 3'd2;
  localparam opcode_t OP_POP   = 3'd3;
  localparam opcode_t OP_CALL  = 3'd4;
  localparam opcode_t OP_RET   = 3'd5;
  localparam opcode_t OP_INT   = 3'd6;
  localparam opcode_t OP_RTI   = 3'd7;

  localparam dsel_t DSEL_ALU = 2'b00;
  localparam dsel_t DSEL_PCL = 2'b01;
  localparam dsel_t DSEL_PCH = 2'b10;
  localparam dsel_t DSEL_CCR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR1,
    ST_WR2,
    ST_WR3,
    ST_RD1,
    ST_RD2,
    ST_RD3,
    ST_CAP
  } state_t;

  // Everything except LOAD/STORE addresses memory through the stack pointer.
  function automatic logic uses_stack(input opcode_t op);
    return (op != OP_LOAD) && (op != OP_STORE);
  endfunction

endpackage

// File: rtl/dmem_stack_sequencer_if.sv
// Execute-stage request handshake plus data-memory strobes and return
// registers of the stack sequencer.
interface dmem_stack_sequencer_if;
  import dmem_stack_sequencer_pkg::*;

  logic        op_valid;
  opcode_t     op_code;
  logic        op_ready;
  logic        stall;
  logic        mem_rd;
  logic        mem_wr;
  logic        stack_sel;
  dsel_t       data_sel;
  logic [15:0] mem_rdata;
  logic [15:0] pop_data;
  logic [31:0] pc_ret;
  logic [2:0]  ccr_ret;
  logic        done;

  modport master (
    output op_valid, op_code, mem_rdata,
    input  op_ready, stall, mem_rd, mem_wr, stack_sel, data_sel,
           pop_data, pc_ret, ccr_ret, done
  );

  modport slave (
    input  op_valid, op_code, mem_rdata,
    output op_ready, stall, mem_rd, mem_wr, stack_sel, data_sel,
           pop_data, pc_ret, ccr_ret, done
  );

endinterface

// File: rtl/dmem_stack_sequencer.sv
// Multi-cycle data-memory controller: sequences CALL/INT pushes and RET/RTI
// pops of PC and CCR, capturing popped words for fetch and the flags.
module dmem_stack_sequencer
  import dmem_stack_sequencer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  dmem_stack_sequencer_if.slave bus
);

  state_t      state;
  state_t      state_next;
  opcode_t     op_q;
  logic        accept;
  logic        mem_rd;
  logic        mem_wr;
  logic        stack_sel;
  dsel_t       data_sel;
  logic        done;
  logic [15:0] pop_data_q;
  logic [31:0] pc_ret_q;
  logic [2:0]  ccr_ret_q;

  assign bus.op_ready  = (state == ST_IDLE);
  assign bus.stall     = ~bus.op_ready;
  assign accept        = bus.op_valid && bus.op_ready && rst;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.stack_sel = stack_sel;
  assign bus.data_sel  = data_sel;
  assign bus.done      = done;
  assign bus.pop_data  = pop_data_q;
  assign bus.pc_ret    = pc_ret_q;
  assign bus.ccr_ret   = ccr_ret_q;

  // The accept cycle performs the first step of a sequence, so IDLE decodes
  // from op_code and jumps straight to the second step.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    stack_sel  = 1'b0;
    data_sel   = DSEL_ALU;
    done       = 1'b0;
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          stack_sel = uses_stack(bus.op_code);
          case (bus.op_code)
            OP_STORE, OP_PUSH: begin
              mem_wr = 1'b1;
              done   = 1'b1;
            end
            OP_LOAD, OP_POP: begin
              mem_rd     = 1'b1;
              state_next = ST_CAP;
            end
            OP_CALL, OP_INT: begin
              mem_wr     = 1'b1;
              data_sel   = DSEL_PCH;
              state_next = ST_WR2;
            end
            default: begin
              mem_rd     = 1'b1;
              state_next = ST_RD2;
            end
          endcase
        end
      end
      ST_WR1: begin
        mem_wr     = 1'b1;
        stack_sel  = 1'b1;
        data_sel   = DSEL_PCH;
        state_next = ST_WR2;
      end
      ST_WR2: begin
        mem_wr    = 1'b1;
        stack_sel = 1'b1;
        data_sel  = DSEL_PCL;
        if (op_q == OP_INT) begin
          state_next = ST_WR3;
        end else begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WR3: begin
        mem_wr     = 1'b1;
        stack_sel  = 1'b1;
        data_sel   = DSEL_CCR;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_RD1: begin
        mem_rd     = 1'b1;
        stack_sel  = 1'b1;
        state_next = ST_RD2;
      end
      ST_RD2: begin
        mem_rd     = 1'b1;
        stack_sel  = 1'b1;
        state_next = (op_q == OP_RTI) ? ST_RD3 : ST_CAP;
      end
      ST_RD3: begin
        mem_rd     = 1'b1;
        stack_sel  = 1'b1;
        state_next = ST_CAP;
      end
      ST_CAP: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // Each popped word arrives the cycle after its read; the latched opcode
  // picks which return register it lands in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= OP_LOAD;
      pop_data_q <= '0;
      pc_ret_q   <= '0;
      ccr_ret_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q <= bus.op_code;
      end
      unique case (state)
        ST_RD2: begin
          if (op_q == OP_RTI) begin
            ccr_ret_q <= bus.mem_rdata[2:0];
          end else begin
            pc_ret_q[15:0] <= bus.mem_rdata;
          end
        end
        ST_RD3: pc_ret_q[15:0] <= bus.mem_rdata;
        ST_CAP: begin
          if ((op_q == OP_LOAD) || (op_q == OP_POP)) begin
            pop_data_q <= bus.mem_rdata;
          end else begin
            pc_ret_q[31:16] <= bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_stack_sequencer.sv
// Self-checking bench for dmem_stack_sequencer: per-operation expected output
// traces plus word-level return-register model, directed and random traffic.
module tb_dmem_stack_sequencer;
  import dmem_stack_sequencer_pkg::*;

  typedef struct packed {
    logic  rd;
    logic  wr;
    logic  ss;
    dsel_t ds;
    logic  done;
    logic  ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  exp_t        exp_q[$];
  logic [15:0] words[$];
  opcode_t     cur_op = OP_LOAD;
  logic [15:0] exp_pop = '0;
  logic [31:0] exp_pc = '0;
  logic [2:0]  exp_ccr = '0;

  dmem_stack_sequencer_if bus();

  dmem_stack_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic rd, input logic wr, input logic ss,
                              input dsel_t ds, input logic dn, input logic rdy);
    exp_t e;
    e.rd = rd; e.wr = wr; e.ss = ss; e.ds = ds; e.done = dn; e.ready = rdy;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cycle, act, expv);
    end
  endtask

  // Expected cycle-by-cycle outputs of one accepted operation, accept cycle first.
  task automatic buildTrace(input opcode_t op);
    logic ss;
    ss = (op != OP_LOAD) && (op != OP_STORE);
    case (op)
      OP_STORE, OP_PUSH: exp_q.push_back(mk(0, 1, ss, DSEL_ALU, 1, 1));
      OP_LOAD, OP_POP: begin
        exp_q.push_back(mk(1, 0, ss, DSEL_ALU, 0, 1));
        exp_q.push_back(mk(0, 0, 0, DSEL_ALU, 1, 0));
      end
      OP_CALL, OP_INT: begin
        exp_q.push_back(mk(0, 1, 1, DSEL_PCH, 0, 1));
        exp_q.push_back(mk(0, 1, 1, DSEL_PCL, op == OP_CALL, 0));
        if (op == OP_INT) exp_q.push_back(mk(0, 1, 1, DSEL_CCR, 1, 0));
      end
      default: begin
        exp_q.push_back(mk(1, 0, 1, DSEL_ALU, 0, 1));
        exp_q.push_back(mk(1, 0, 1, DSEL_ALU, 0, 0));
        if (op == OP_RTI) exp_q.push_back(mk(1, 0, 1, DSEL_ALU, 0, 0));
        exp_q.push_back(mk(0, 0, 0, DSEL_ALU, 1, 0));
      end
    endcase
  endtask

  // words[k] is mem_rdata seen k cycles after accept; reads return data one cycle later.
  task automatic finalizeCaptures();
    logic [15:0] w;
    case (cur_op)
      OP_LOAD, OP_POP: exp_pop = words[1];
      OP_RET: exp_pc = {words[2], words[1]};
      OP_RTI: begin
        w = words[1];
        exp_ccr = w[2:0];
        exp_pc = {words[3], words[2]};
      end
      default: ;
    endcase
  endtask

  task automatic checkCaptures();
    checkOutput("pop_data", {16'd0, bus.pop_data}, {16'd0, exp_pop});
    checkOutput("pc_ret", bus.pc_ret, exp_pc);
    checkOutput("ccr_ret", {29'd0, bus.ccr_ret}, {29'd0, exp_ccr});
  endtask

  task automatic checkCycle();
    exp_t e;
    exp_t act;
    act = {bus.mem_rd, bus.mem_wr, bus.stack_sel, bus.data_sel, bus.done, bus.op_ready};
    if (!rst) begin
      exp_q.delete();
      words.delete();
      exp_pop = '0;
      exp_pc  = '0;
      exp_ccr = '0;
      e = mk(0, 0, 0, DSEL_ALU, 0, 1);
      checkOutput("reset_strobes", {25'd0, act}, {25'd0, e});
      checkCaptures();
      return;
    end
    if (exp_q.size() == 0) begin
      checkCaptures();
      if (bus.op_valid) begin
        buildTrace(bus.op_code);
        cur_op = bus.op_code;
        words.delete();
      end
    end
    if (exp_q.size() == 0) begin
      e = mk(0, 0, 0, DSEL_ALU, 0, 1);
    end else begin
      e = exp_q.pop_front();
      words.push_back(bus.mem_rdata);
      if (exp_q.size() == 0) finalizeCaptures();
    end
    checkOutput("strobes", {25'd0, act}, {25'd0, e});
    checkOutput("stall", {31'd0, bus.stall}, {31'd0, ~e.ready});
  endtask

  task automatic applyStimulus(input logic v, input opcode_t code, input logic [15:0] rdata,
                               input logic rstv);
    bus.op_valid  = v;
    bus.op_code   = code;
    bus.mem_rdata = rdata;
    rst           = rstv;
    @(negedge clk);
    checkCycle();
    cycle++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.op_valid  = 1'b0;
    bus.op_code   = OP_LOAD;
    bus.mem_rdata = '0;
    #1;
    applyStimulus(0, OP_LOAD, 16'h0, 0);
    applyStimulus(0, OP_LOAD, 16'h0, 0);
    applyStimulus(0, OP_LOAD, 16'h0, 1);
    checkOutput("reset_ready", {31'd0, bus.op_ready}, 32'd1);
    checkOutput("reset_pc_ret", bus.pc_ret, 32'd0);

    $display("[TB] store/push back-to-back");
    applyStimulus(1, OP_STORE, 16'h1111, 1);
    applyStimulus(1, OP_PUSH, 16'h2222, 1);
    applyStimulus(0, OP_LOAD, 16'h0, 1);

    $display("[TB] call and int");
    applyStimulus(1, OP_CALL, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0, 1);
    applyStimulus(1, OP_INT, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0, 1);

    $display("[TB] rti restore");
    applyStimulus(1, OP_RTI, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0005, 1);
    applyStimulus(0, OP_LOAD, 16'hBEEF, 1);
    applyStimulus(0, OP_LOAD, 16'h1234, 1);
    checkOutput("rti_ccr_literal", {29'd0, bus.ccr_ret}, 32'd5);
    checkOutput("rti_pc_literal", bus.pc_ret, 32'h1234BEEF);

    $display("[TB] pop with request held during capture");
    applyStimulus(1, OP_POP, 16'h0, 1);
    applyStimulus(1, OP_POP, 16'hA5A5, 1);
    checkOutput("pop_literal", {16'd0, bus.pop_data}, 32'h0000A5A5);
    applyStimulus(1, OP_POP, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h2222, 1);
    checkOutput("pop2_literal", {16'd0, bus.pop_data}, 32'h00002222);

    $display("[TB] reset in the middle of rti");
    applyStimulus(1, OP_RTI, 16'h0, 1);
    applyStimulus(0, OP_LOAD, 16'h0007, 0);
    applyStimulus(0, OP_LOAD, 16'h0, 1);
    checkOutput("midrst_ready", {31'd0, bus.op_ready}, 32'd1);
    checkOutput("midrst_pc_ret", bus.pc_ret, 32'd0);
    checkOutput("midrst_ccr_ret", {29'd0, bus.ccr_ret}, 32'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 7)),
                    16'($urandom), 1'($urandom_range(0, 299) != 0));
    end
    applyStimulus(0, OP_LOAD, 16'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_stack_sequencer.md
# dmem_stack_sequencer

Multi-cycle controller in front of the data-memory stage: accepts one memory operation per handshake from the execute stage and drives the data memory's read/write strobes, address-source select and write-data select. It sequences the multi-word stack operations: CALL, RET, INT and RTI push or pop PC-high, PC-low and CCR over several cycles. It captures popped words into return registers for the fetch stage and CCR. It stalls the pipeline while a sequence is in flight.

## Interface
- RD_LAT, 1: cycles from a read strobe to valid `mem_rdata`. Only 1 is supported.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- op_valid  in  1  operation request from execute stage
- op_code  in  3  0 LOAD, 1 STORE, 2 PUSH, 3 POP, 4 CALL, 5 RET, 6 INT, 7 RTI
- op_ready  out  1  high only in IDLE; a request is accepted on op_valid && op_ready
- stall  out  1  equals ~op_ready
- mem_rd  out  1  drives data-memory MR
- mem_wr  out  1  drives data-memory MW
- stack_sel  out  1  address source: 1 selects SP, 0 selects ALU address
- data_sel  out  2  write-data source: 00 ALU, 01 PC-low, 10 PC-high, 11 CCR
- mem_rdata  in  16  data-memory read data
- pop_data  out  16  word returned by LOAD/POP
- pc_ret  out  32  {PC-high, PC-low} restored by RET/RTI
- ccr_ret  out  3  CCR restored by RTI
- done  out  1  one-cycle pulse: operation complete, captured outputs valid

## Operation
- States: IDLE, WR1, WR2, WR3, RD1, RD2, RD3, CAP.
- IDLE, accept:
  - STORE/PUSH: one write, in the accept cycle; `data_sel`=00; `done` in the same cycle; stay in IDLE.
  - LOAD/POP: `mem_rd` in the accept cycle, then go to CAP.
  - CALL/INT: go to WR1.
  - RET/RTI: go to RD1.
- In the accept cycle of a multi-cycle op, strobes are driven from the first sequence step. IDLE therefore asserts the WR1 or RD1 outputs combinationally, and the FSM advances to the following step.
- `stack_sel`=1 for PUSH, POP, CALL, RET, INT and RTI; 0 for LOAD and STORE.
- Push order is PC-high, PC-low, then CCR (INT only). The memory stack grows down.
  - CALL: write PCH, write PCL, with `done` on the PCL write.
  - INT: write PCH, PCL, CCR, with `done` on the CCR write.
- Pop order is the reverse. Each word is captured in the cycle after its read.
  - RTI: read CCR; read PCL and capture `ccr_ret`; read PCH and capture `pc_ret[15:0]`; CAP captures `pc_ret[31:16]` and pulses `done`.
  - RET: read PCL; read PCH and capture low; CAP captures high and pulses `done`.
- CAP with LOAD/POP: `pop_data` <= `mem_rdata`, pulse `done`, return to IDLE.
- An internal op register holds the accepted opcode. It decides which capture target and which next state apply.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `pop_data`, `pc_ret` and `ccr_ret` hold their values until the next capture.
- Opcodes are 3 bits, so every value is defined; there is no illegal-opcode path.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE. `mem_rd`=`mem_wr`=`stack_sel`=0, `data_sel`=00, `done`=0, `pop_data`=0, `pc_ret`=0, `ccr_ret`=0, op register=0.
- Reset asserted mid-sequence aborts immediately. Partial captures are discarded (zeroed) and no `done` is issued.
- Latency from accept to `done`:
  - STORE/PUSH: 0 cycles.
  - LOAD/POP: 1.
  - CALL: 1.
  - INT: 2.
  - RET: 2.
  - RTI: 3.
- `op_ready` drops in the cycle after accepting a multi-cycle op and rises in the cycle after `done`. Back-to-back accepts are therefore possible only for STORE/PUSH.
- `op_valid` while not ready is ignored; the requester must hold it.
- All strobe and select outputs are Moore-decoded from state, except in the IDLE accept cycle, where they decode from `op_code`.

## Structure
- Shared package holds:
  - the opcode constants (OP_LOAD … OP_RTI),
  - the data_sel encodings (DSEL_ALU, DSEL_PCL, DSEL_PCH, DSEL_CCR),
  - the FSM state enum.
- Single module; no sub-module needed. The capture-register bank is inline.

## Test plan
- Reset mid-RTI (assert `rst`=0 while in RD2): all outputs 0 in the same cycle; IDLE and `op_ready`=1 after release.
- STORE then PUSH back-to-back: in each accept cycle `mem_wr`=1 and `data_sel`=00; `stack_sel`=0 then 1; `done` each cycle; `op_ready` stays 1.
- CALL: strobes over 2 cycles are `mem_wr`=1 with `data_sel`=10 then 01, and `stack_sel`=1; `done` on cycle 2; `stall` high for 1 cycle after accept.
- INT: `data_sel` sequence is 10, 01, 11 with `mem_wr` high for 3 cycles; `done` on the 3rd.
- RTI with `mem_rdata` returning 0x0005, 0xBEEF, 0x1234 on successive post-read cycles: `ccr_ret`=3'b101, `pc_ret`=0x1234BEEF, `done` 3 cycles after accept, `mem_rd` high exactly 3 cycles.
- POP with `mem_rdata`=0xA5A5, plus `op_valid` held during CAP: `pop_data`=0xA5A5 with `done`; the held request is accepted only in the following cycle.
